// File: rtl/uart_calc_ctl.sv
// Byte-stream calculator: parses operand, operand, operator from the UART receive strobe,
// shows the 4-bit result plus carry/borrow on the LEDs and reports it as a 3-byte ASCII message.
module uart_calc_ctl (
    input  logic       clk12m,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    input  logic       tx_busy,
    output logic [4:0] leds,
    output logic       err
);

    typedef enum logic [1:0] {P_EMPTY, P_ONE, P_TWO} p_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} t_state_t;

    p_state_t   p_state, p_next;
    t_state_t   t_state, t_next;
    logic [3:0] opa, opb, opa_next, opb_next;
    logic [4:0] leds_next;
    logic [1:0] idx, idx_next;
    logic [7:0] tx_data_next, msg_byte;
    logic       tx_data_rdy_next, err_next, start_tx;
    logic       is_operand, is_plus, is_minus, tx_active;

    assign is_operand = (rx_data < 8'h10);
    assign is_plus    = (rx_data == 8'h2B);
    assign is_minus   = (rx_data == 8'h2D);
    assign tx_active  = (t_state != T_IDLE);

    // Message bytes come straight from leds: leds cannot change while a message is in flight.
    always_comb begin
        msg_byte = 8'h0D;
        case (idx)
            2'd0: msg_byte = 8'h30 + {7'd0, leds[4]};
            2'd1: msg_byte = (leds[3:0] < 4'd10) ? 8'h30 + {4'd0, leds[3:0]}
                                                 : 8'h37 + {4'd0, leds[3:0]};
            default: msg_byte = 8'h0D;
        endcase
    end

    always_comb begin
        p_next    = p_state;
        opa_next  = opa;
        opb_next  = opb;
        leds_next = leds;
        err_next  = 1'b0;
        start_tx  = 1'b0;
        if (rx_data_rdy) begin
            if (is_operand) begin
                case (p_state)
                    P_EMPTY: begin
                        opa_next = rx_data[3:0];
                        p_next   = P_ONE;
                    end
                    P_ONE: begin
                        opb_next = rx_data[3:0];
                        p_next   = P_TWO;
                    end
                    default: begin
                        opa_next = opb;
                        opb_next = rx_data[3:0];
                    end
                endcase
            end else if ((is_plus || is_minus) && p_state == P_TWO && !tx_active) begin
                if (is_plus)
                    leds_next = {1'b0, opa} + {1'b0, opb};
                else
                    leds_next = {(opa < opb), opa - opb};
                opa_next = 4'd0;
                opb_next = 4'd0;
                p_next   = P_EMPTY;
                start_tx = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_comb begin
        t_next           = t_state;
        idx_next         = idx;
        tx_data_next     = 8'h00;
        tx_data_rdy_next = 1'b0;
        case (t_state)
            T_IDLE: begin
                if (start_tx) begin
                    t_next   = T_SEND;
                    idx_next = 2'd0;
                end
            end
            T_SEND: begin
                if (!tx_busy) begin
                    tx_data_next     = msg_byte;
                    tx_data_rdy_next = 1'b1;
                    t_next           = T_GAP;
                end
            end
            T_GAP: begin
                if (idx == 2'd2) begin
                    idx_next = 2'd0;
                    t_next   = T_IDLE;
                end else begin
                    idx_next = idx + 2'd1;
                    t_next   = T_SEND;
                end
            end
            default: t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            p_state     <= P_EMPTY;
            t_state     <= T_IDLE;
            opa         <= 4'd0;
            opb         <= 4'd0;
            idx         <= 2'd0;
            leds        <= 5'd0;
            tx_data     <= 8'h00;
            tx_data_rdy <= 1'b0;
            err         <= 1'b0;
        end else begin
            p_state     <= p_next;
            t_state     <= t_next;
            opa         <= opa_next;
            opb         <= opb_next;
            idx         <= idx_next;
            leds        <= leds_next;
            tx_data     <= tx_data_next;
            tx_data_rdy <= tx_data_rdy_next;
            err         <= err_next;
        end
    end

endmodule

// File: tb/tb_uart_calc_ctl.sv
// Directed bench for uart_calc_ctl: the driver pushes expected message bytes into a queue,
// a monitor pops and compares them whenever the DUT strobes tx_data_rdy.
module tb_uart_calc_ctl;

    logic       clk12m;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic [7:0] tx_data;
    logic       tx_data_rdy;
    logic       tx_busy;
    logic [4:0] leds;
    logic       err;

    logic [7:0] exp_q[$];
    int         strobe_times[$];
    int         strobe_count = 0;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         op_cyc;
    int         fall_cyc;

    uart_calc_ctl dut (
        .clk12m      (clk12m),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .tx_data     (tx_data),
        .tx_data_rdy (tx_data_rdy),
        .tx_busy     (tx_busy),
        .leds        (leds),
        .err         (err)
    );

    initial begin
        clk12m = 1'b0;
        forever #5 clk12m = ~clk12m;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        else
            passed++;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [7:0] exp_byte;
        forever begin
            @(posedge clk12m);
            #1;
            cyc++;
            if (tx_data_rdy) begin
                strobe_count++;
                strobe_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checkOutput("tx_unexpected", {31'd0, tx_data_rdy}, 32'd0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte});
                end
            end else begin
                checkOutput("tx_idle_zero", {24'd0, tx_data}, 32'd0);
            end
        end
    end

    // Called at a falling edge; consumes exactly one cycle so calls run back to back.
    task automatic applyStimulus(input logic [7:0] b, input logic exp_err);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(negedge clk12m);
        op_cyc      = cyc;
        rx_data_rdy = 1'b0;
        rx_data     = 8'h00;
        checkOutput("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic sendOp(input logic [7:0] op, input logic [4:0] exp_leds,
                          input logic [7:0] m0, input logic [7:0] m1);
        strobe_count = 0;
        strobe_times.delete();
        exp_q.push_back(m0);
        exp_q.push_back(m1);
        exp_q.push_back(8'h0D);
        applyStimulus(op, 1'b0);
        checkOutput("leds", {27'd0, leds}, {27'd0, exp_leds});
    endtask

    task automatic waitStrobes(input int target);
        int budget = 200;
        while (strobe_count < target && budget > 0) begin
            @(negedge clk12m);
            budget--;
        end
        if (strobe_count < target)
            checkOutput("strobe_timeout", strobe_count, target);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk12m);
    endtask

    task automatic checkSpacing();
        if (strobe_times.size() == 3) begin
            checkOutput("first_latency", strobe_times[0] - op_cyc, 1);
            checkOutput("gap01", strobe_times[1] - strobe_times[0], 2);
            checkOutput("gap12", strobe_times[2] - strobe_times[1], 2);
        end else begin
            checkOutput("strobe_count", strobe_times.size(), 3);
        end
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        tx_busy     = 1'b0;
        idle(2);
        checkOutput("rst_leds", {27'd0, leds}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_tx_rdy", {31'd0, tx_data_rdy}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        idle(1);

        $display("[TB] basic add 4+3");
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h03, 1'b0);
        sendOp(8'h2B, 5'b00111, 8'h30, 8'h37);
        waitStrobes(3);
        idle(2);

        $display("[TB] back-to-back messages, strobe spacing");
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h04, 1'b0);
        sendOp(8'h2B, 5'b01000, 8'h30, 8'h38);
        waitStrobes(3);
        checkSpacing();
        idle(2);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h05, 1'b0);
        sendOp(8'h2B, 5'b01001, 8'h30, 8'h39);
        waitStrobes(3);
        checkSpacing();
        idle(2);

        $display("[TB] carry and borrow");
        applyStimulus(8'h0C, 1'b0);
        applyStimulus(8'h07, 1'b0);
        sendOp(8'h2B, 5'b10011, 8'h31, 8'h33);
        waitStrobes(3);
        idle(2);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h09, 1'b0);
        sendOp(8'h2D, 5'b11010, 8'h31, 8'h41);
        waitStrobes(3);
        idle(2);

        $display("[TB] operand shift and rejected bytes");
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h05, 1'b0);
        sendOp(8'h2B, 5'b00111, 8'h30, 8'h37);
        waitStrobes(3);
        idle(2);
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h2B, 1'b1);
        checkOutput("leds_after_err", {27'd0, leds}, {27'd0, 5'b00111});
        applyStimulus(8'h41, 1'b1);
        checkOutput("leds_after_bad", {27'd0, leds}, {27'd0, 5'b00111});

        $display("[TB] tx_busy hold and operator during transmit");
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        sendOp(8'h2B, 5'b00010, 8'h30, 8'h32);
        waitStrobes(1);
        tx_busy = 1'b1;
        applyStimulus(8'h05, 1'b0);
        applyStimulus(8'h06, 1'b0);
        applyStimulus(8'h2B, 1'b1);
        checkOutput("leds_busy_op", {27'd0, leds}, {27'd0, 5'b00010});
        idle(47);
        checkOutput("held_strobes", strobe_count, 1);
        tx_busy  = 1'b0;
        fall_cyc = cyc;
        waitStrobes(2);
        if (strobe_times.size() >= 2)
            checkOutput("busy_release", strobe_times[1] - fall_cyc, 1);
        waitStrobes(3);
        idle(2);

        $display("[TB] reset mid-message");
        sendOp(8'h2B, 5'b01011, 8'h30, 8'h42);
        waitStrobes(1);
        idle(1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("mid_rst_leds", {27'd0, leds}, 32'd0);
        checkOutput("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("mid_rst_tx_rdy", {31'd0, tx_data_rdy}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(10);
        checkOutput("no_strobe_after_rst", strobe_count, 1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h02, 1'b0);
        sendOp(8'h2B, 5'b00100, 8'h30, 8'h34);
        waitStrobes(3);
        checkSpacing();
        idle(4);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
